// File: rtl/key_event_if.sv
// key_event_if
//   Groups the per-key signals between the input synchronizer side and the
//   player-control side.
//   key_in      : synchronized key level, 1 = pressed
//   press_pulse : single-cycle move event
//   held        : debounced key-held level
//   master modport: drives key_in, observes the events (stimulus/upstream).
//   slave modport : consumes key_in, produces the events (key_event_gen).
interface key_event_if;
    logic key_in;
    logic press_pulse;
    logic held;

    modport master (
        output key_in,
        input  press_pulse,
        input  held
    );

    modport slave (
        input  key_in,
        output press_pulse,
        output held
    );
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen
//   Debounces one synchronized, active-high key level and turns it into
//   single-cycle move events. With KEY_AUTOREPEAT_EN defined, a held key
//   also produces auto-repeat events (first after REPEAT_DELAY edges, then
//   every REPEAT_RATE edges). Without it, a single HELD state waits for the
//   release and exactly one event is produced per debounced press.
//
//   Ports:
//     CLK : system clock, all logic on posedge
//     RST : asynchronous, active-high reset
//     kif : key_event_if.slave (key_in in; press_pulse, held out, registered)
//
//   Optional feature macro: KEY_AUTOREPEAT_EN
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | key released and debounced
//   DEB_PRESS    | counting consecutive high samples
//   HELD_DELAY   | pressed, waiting for the first repeat (autorepeat)
//   HELD_REPEAT  | pressed, emitting periodic repeats (autorepeat)
//   HELD         | pressed, waiting for release (no autorepeat)
//   DEB_RELEASE  | counting consecutive low samples; held still 1
module key_event_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_RATE     = 3,
    parameter int CNT_W           = 8
) (
    input  logic        CLK,
    input  logic        RST,
    key_event_if.slave  kif
);

`ifdef KEY_AUTOREPEAT_EN
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_t;
    localparam state_t ST_HOLD_ENTRY = ST_HELD_DELAY;
`else
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD        = 3'd2,
        ST_DEB_RELEASE = 3'd4
    } state_t;
    localparam state_t ST_HOLD_ENTRY = ST_HELD;
`endif

    // The counter only ever needs to reach the largest terminal value, so it
    // saturates there instead of wrapping.
    localparam int MAX_AB   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam logic [CNT_W-1:0] CNT_CEIL = CNT_W'(MAX_ALL - 1);

    // Terminal counts: the count is compared before the current sample is
    // added, hence the -1.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif
    localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_pulse_q, press_pulse_d;
    logic             held_q, held_d;

    logic [CNT_W-1:0] cnt_inc;
    state_t           rel_state;
    logic [CNT_W-1:0] rel_cnt;

    always_comb begin
        cnt_inc = (cnt_q >= CNT_CEIL) ? cnt_q : cnt_q + 1'b1;

        // First low sample while held: it is release sample 1, which already
        // completes the release debounce when only one sample is required.
        if (DEB_ONE) begin
            rel_state = ST_IDLE;
            rel_cnt   = '0;
        end else begin
            rel_state = ST_DEB_RELEASE;
            rel_cnt   = CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (kif.key_in) begin
                    if (DEB_ONE) begin
                        state_d       = ST_HOLD_ENTRY;
                        cnt_d         = '0;
                        press_pulse_d = 1'b1;
                    end else begin
                        state_d = ST_DEB_PRESS;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            ST_DEB_PRESS: begin
                if (!kif.key_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d       = ST_HOLD_ENTRY;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

`ifdef KEY_AUTOREPEAT_EN
            // A low sample is checked first so a release on the expiry edge
            // suppresses the repeat.
            ST_HELD_DELAY: begin
                if (!kif.key_in) begin
                    state_d = rel_state;
                    cnt_d   = rel_cnt;
                end else if (cnt_q >= RD_LAST) begin
                    state_d       = ST_HELD_REPEAT;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_HELD_REPEAT: begin
                if (!kif.key_in) begin
                    state_d = rel_state;
                    cnt_d   = rel_cnt;
                end else if (cnt_q >= RR_LAST) begin
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`else
            ST_HELD: begin
                if (!kif.key_in) begin
                    state_d = rel_state;
                    cnt_d   = rel_cnt;
                end
            end
`endif

            ST_DEB_RELEASE: begin
                if (kif.key_in) begin
                    cnt_d = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Every reachable next state is legal, so held is "not idle and not
        // still debouncing the press".
        held_d = (state_d != ST_IDLE) && (state_d != ST_DEB_PRESS);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            press_pulse_q <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse_q <= press_pulse_d;
            held_q        <= held_d;
        end
    end

    assign kif.press_pulse = press_pulse_q;
    assign kif.held        = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen
//   Directed bench for key_event_gen with default parameters. Expected
//   {press_pulse, held} per edge is queued when key_in is driven and compared
//   after the edge. Autorepeat expectations are selected by KEY_AUTOREPEAT_EN.
module tb_key_event_gen;
    logic CLK = 1'b0;
    logic RST;

    key_event_if kif();

    key_event_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .CNT_W          (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .kif(kif)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

`ifdef KEY_AUTOREPEAT_EN
    localparam int RST_AT = 17;
`else
    localparam int RST_AT = 6;
`endif

    // Pulse expected on edge i of a continuous hold starting from IDLE.
    function automatic logic pulse_exp(input int i);
`ifdef KEY_AUTOREPEAT_EN
        return (i == 4) || (i == 14) || ((i > 14) && (((i - 14) % 3) == 0));
`else
        return (i == 4);
`endif
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: pulse/held got=%b required=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic k, input logic ep, input logic eh);
        logic [1:0] e;
        kif.key_in = k;
        exp_q.push_back({ep, eh});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check(tag, {kif.press_pulse, kif.held}, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bounce [7];
        logic glitch [7];
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        glitch = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        RST        = 1'b1;
        kif.key_in = 1'b0;
        @(posedge CLK);
        #1;
        check("reset_state", {kif.press_pulse, kif.held}, 2'b00);
        RST = 1'b0;

        for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 1'b0, 1'b0);

        // Clean press held 30 edges, then release.
        for (int i = 1; i <= 30; i++) cyc("press_hold", 1'b1, pulse_exp(i), i >= 4);
        for (int i = 1; i <= 6; i++) cyc("release", 1'b0, 1'b0, i < 4);

        // Bounce rejection, then a full press proves the FSM restarted from IDLE.
        for (int i = 0; i < 7; i++) cyc("bounce", bounce[i], 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) cyc("after_bounce", 1'b1, i == 4, i >= 4);

        // Glitch while releasing: held drops on the 4th consecutive low.
        for (int i = 0; i < 7; i++) cyc("release_glitch", glitch[i], 1'b0, i < 6);
        for (int i = 0; i < 2; i++) cyc("idle2", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a hold.
        for (int i = 1; i <= RST_AT; i++) cyc("hold_pre_rst", 1'b1, pulse_exp(i), i >= 4);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_mid_hold", {kif.press_pulse, kif.held}, 2'b00);
        @(posedge CLK);
        #1;
        check("rst_held_over_edge", {kif.press_pulse, kif.held}, 2'b00);
        RST = 1'b0;
        for (int i = 1; i <= 8; i++) cyc("after_rst", 1'b1, i == 4, i >= 4);
        for (int i = 1; i <= 6; i++) cyc("release2", 1'b0, 1'b0, i < 4);

`ifdef KEY_AUTOREPEAT_EN
        // Release on the edge where the repeat after edge 20 would fire.
        for (int i = 1; i <= 19; i++) cyc("hold_pre_coincide", 1'b1, pulse_exp(i), i >= 4);
        cyc("coincide_edge", 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) cyc("coincide_release", 1'b0, 1'b0, j < 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
